// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with multi-cycle logical right shift.
// Define ALU_SEQ_STICKY_OF_EN to add the OF_sticky output.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] aluin_a,
  input  logic [WIDTH-1:0] aluin_b,
  input  logic [3:0]       OPCODE,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             Cout,
  output logic             OF,
  output logic             Z,
`ifdef ALU_SEQ_STICKY_OF_EN
  output logic             OF_sticky,
`endif
  output logic             ERR
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic armed;
  logic [SHW-1:0] cnt;
  logic acc, is_shr;
  logic [SHW-1:0] amt;
  logic [WIDTH-1:0] bb, sum, res_nx;
  logic ci, c_top, c_msb, of_add, cout_nx, of_nx, err_nx;
  assign in_ready = armed && state == IDLE;
  assign out_valid = state == DONE;
  assign acc = in_valid && in_ready;
  assign is_shr = OPCODE == 4'b1000;
  assign amt = aluin_b[SHW-1:0];
  // Subtract reuses the adder as A + ~B + 1.
  assign bb = OPCODE == 4'b0011 ? ~aluin_b : aluin_b;
  assign ci = OPCODE == 4'b0011 ? 1'b1 : OPCODE == 4'b0001 ? Cin : 1'b0;
  assign {c_top, sum} = {1'b0, aluin_a} + {1'b0, bb} + (WIDTH+1)'(ci);
  assign c_msb = sum[WIDTH-1] ^ aluin_a[WIDTH-1] ^ bb[WIDTH-1];
  assign of_add = c_msb ^ c_top;
  always_comb begin
    res_nx = '0;
    cout_nx = 1'b0;
    of_nx = 1'b0;
    err_nx = 1'b0;
    case (OPCODE)
      4'b0001, 4'b0011: begin
        res_nx = sum;
        cout_nx = c_top;
        of_nx = of_add;
      end
      4'b0010: begin
        res_nx = sum;
        of_nx = of_add;
      end
      4'b0100: res_nx = aluin_a & aluin_b;
      4'b0101: res_nx = ~(aluin_a | aluin_b);
      4'b0110: res_nx = ~(aluin_a ^ aluin_b);
      4'b0111: res_nx = ~aluin_a;
      4'b1000: res_nx = aluin_a;
      default: err_nx = 1'b1;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = (is_shr && amt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == SHW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed <= 1'b0;
      cnt <= '0;
      alu_out <= '0;
      Cout <= 1'b0;
      OF <= 1'b0;
      Z <= 1'b0;
      ERR <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (acc) begin
        alu_out <= res_nx;
        Cout <= cout_nx;
        OF <= of_nx;
        ERR <= err_nx;
        Z <= res_nx == '0;
        cnt <= is_shr ? amt : '0;
      end else if (state == SHIFT) begin
        alu_out <= alu_out >> 1;
        Z <= (alu_out >> 1) == '0;
        cnt <= cnt - SHW'(1);
      end
    end
`ifdef ALU_SEQ_STICKY_OF_EN
  // Only add/sub raise OF, and those always go straight to DONE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) OF_sticky <= 1'b0;
    else if (acc && of_nx) OF_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] aluin_a = '0;
  logic [7:0] aluin_b = '0;
  logic [3:0] OPCODE = '0;
  logic Cin = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] alu_out;
  logic Cout, OF, Z, ERR;
`ifdef ALU_SEQ_STICKY_OF_EN
  logic of_sticky;
`endif
  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluin_a(aluin_a), .aluin_b(aluin_b), .OPCODE(OPCODE), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .Cout(Cout), .OF(OF), .Z(Z),
`ifdef ALU_SEQ_STICKY_OF_EN
    .OF_sticky(of_sticky),
`endif
    .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled right after the accept edge so a design that
  // keeps reading live inputs produces the wrong result.
  task automatic run(input string tag, input logic [3:0] opc, input logic [7:0] a,
                     input logic [7:0] b, input logic ci);
    OPCODE = opc; aluin_a = a; aluin_b = b; Cin = ci; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; aluin_a = ~a; aluin_b = ~b; Cin = ~ci; OPCODE = 4'b0100;
  endtask

  task automatic res(input string tag, input logic [7:0] r, input logic c,
                     input logic o, input logic z, input logic e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".alu_out"}, 32'(alu_out), 32'(r));
    chk({tag, ".Cout"}, 32'(Cout), 32'(c));
    chk({tag, ".OF"}, 32'(OF), 32'(o));
    chk({tag, ".Z"}, 32'(Z), 32'(z));
    chk({tag, ".ERR"}, 32'(ERR), 32'(e));
  endtask

  task automatic consume(input string tag);
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ov_fall"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ov_seen;
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.alu_out", 32'(alu_out), 32'd0);
    chk("rst.flags", {28'd0, Cout, OF, Z, ERR}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel.in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rel.in_ready_high", 32'(in_ready), 32'd1);

    run("add_of", 4'b0010, 8'h7F, 8'h01, 1'b0);
    res("add_of", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_SEQ_STICKY_OF_EN
    chk("sticky", 32'(of_sticky), 32'd1);
`endif
    consume("add_of");
    run("adc", 4'b0001, 8'hFF, 8'h00, 1'b1);
    res("adc", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    consume("adc");
    run("sub", 4'b0011, 8'h05, 8'h07, 1'b0);
    res("sub", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("sub");
    run("add_wrap", 4'b0010, 8'hFF, 8'h01, 1'b1);
    res("add_wrap", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    consume("add_wrap");
    run("sub_of", 4'b0011, 8'h80, 8'h01, 1'b0);
    res("sub_of", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    consume("sub_of");
    run("and", 4'b0100, 8'hF0, 8'h3C, 1'b0);
    res("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("and");
    run("nor", 4'b0101, 8'hF0, 8'h0C, 1'b0);
    res("nor", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("nor");
    run("xnor", 4'b0110, 8'hF0, 8'h3C, 1'b0);
    res("xnor", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("xnor");
    run("not", 4'b0111, 8'hA5, 8'h00, 1'b0);
    res("not", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("not");
    run("ill_f", 4'b1111, 8'hFF, 8'hFF, 1'b1);
    res("ill_f", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    consume("ill_f");
    run("ill_0", 4'b0000, 8'h12, 8'h34, 1'b0);
    res("ill_0", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    consume("ill_0");

    run("shr5", 4'b1000, 8'hB4, 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("shr5.wait_ov", 32'(out_valid), 32'd0);
      chk("shr5.wait_ir", 32'(in_ready), 32'd0);
      tick();
    end
    res("shr5", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      res("bp", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    consume("bp");
    run("shr0", 4'b1000, 8'h81, 8'hF8, 1'b0);
    res("shr0", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("shr0");
    run("shr1", 4'b1000, 8'h81, 8'h09, 1'b0);
    chk("shr1.wait_ov", 32'(out_valid), 32'd0);
    tick();
    res("shr1", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("shr1");

    run("rst_mid", 4'b1000, 8'h80, 8'h07, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid.alu_out", 32'(alu_out), 32'd0);
    chk("rst_mid.flags", {28'd0, Cout, OF, Z, ERR}, 32'd0);
    tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    chk("rst_mid.no_result", 32'(ov_seen), 32'd0);
    chk("rst_mid.idle", 32'(in_ready), 32'd1);
    run("post_rst", 4'b0010, 8'h10, 8'h20, 1'b0);
    res("post_rst", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal 4..32).
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), giving the number of bits of aluin_b used as the shift amount.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  operation request.
REQ-006 The module SHALL have port in_ready  output  1  high when a request can be accepted.
REQ-007 The module SHALL have port aluin_a  input  WIDTH  operand A.
REQ-008 The module SHALL have port aluin_b  input  WIDTH  operand B.
REQ-009 The module SHALL have port OPCODE  input  4  operation select.
REQ-010 The module SHALL have port Cin  input  1  carry-in, used by add-with-carry only.
REQ-011 The module SHALL have port out_valid  output  1  result available.
REQ-012 The module SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 The module SHALL have port alu_out  output  WIDTH  registered result.
REQ-014 The module SHALL have ports Cout, OF, Z, ERR  output  1 each; these are the registered carry, signed-overflow, zero and illegal-opcode flags.

Function
REQ-015 The opcodes SHALL be defined as follows:
- 0001: A+B+Cin.
- 0010: A+B.
- 0011: A-B, computed as A+~B+1 with Cin ignored.
- 0100: A&B.
- 0101: ~(A|B).
- 0110: ~(A^B).
- 0111: ~A.
- 1000: logical right shift of A by B[SHW-1:0].
REQ-016 Cout SHALL be the carry out of the MSB for 0001/0011; for 0011, Cout=1 means no borrow. Cout SHALL be 0 for all other opcodes.
REQ-017 OF SHALL be the carry into the MSB XOR the carry out of the MSB for 0001/0010/0011, and SHALL be 0 for all other opcodes.
REQ-018 Z SHALL be 1 exactly when the final alu_out equals 0. For an illegal opcode the result is 0, so Z=1.
REQ-019 An illegal opcode (0000, 1001-1111) SHALL complete in one cycle with alu_out=0, Cout=0, OF=0 and ERR=1. ERR SHALL be 0 for all legal opcodes.
REQ-020 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-021 Operands, OPCODE and Cin SHALL be captured on the edge where in_valid&&in_ready. Input changes after capture SHALL have no effect on the operation in progress.
REQ-022 Non-shift opcodes and shifts by 0 SHALL go from IDLE to DONE on the accept edge: out_valid is high the cycle after acceptance, giving a latency of 1.
REQ-023 A shift by k>0 SHALL go from IDLE to SHIFT, shift one bit per cycle while decrementing a counter, and enter DONE after k shift cycles, giving a latency of k+1 cycles.
REQ-024 In DONE, alu_out and all flags SHALL hold stable while out_ready=0.
REQ-025 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge and out_valid SHALL fall.
REQ-026 A new request SHALL NOT be accepted in the same cycle a result is consumed; the maximum throughput is one operation per 2 cycles.
REQ-027 Wrap-around: add/sub results SHALL be taken modulo 2^WIDTH, with the carry reported only via Cout.
REQ-028 Shift amounts SHALL use only B[SHW-1:0]. Upper bits of B SHALL be ignored for shifts.

Reset
REQ-029 While rst_n=0, in any state including mid-shift, the FSM SHALL go immediately to IDLE.
REQ-030 While rst_n=0, alu_out, Cout, OF, Z, ERR, out_valid and the shift counter SHALL be 0.
REQ-031 While rst_n=0, in_ready SHALL be 0. It SHALL go to 1 from the first clock edge after rst_n goes high.
REQ-032 Any operation in flight at reset SHALL be discarded without producing a result.

Configuration
REQ-033 The macro ALU_SEQ_STICKY_OF_EN SHALL control a sticky overflow port.
- When defined: an extra output OF_sticky (1 bit) SHALL be present. It SHALL be set when a result with OF=1 enters DONE and cleared only by reset.
- When undefined: the OF_sticky port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover these add cases at WIDTH=8:
- OPCODE=0010, A=0x7F, B=0x01 -> after 1 cycle alu_out=0x80, OF=1, Cout=0, Z=0.
- OPCODE=0001, A=0xFF, B=0x00, Cin=1 -> alu_out=0x00, Cout=1, Z=1, OF=0.
REQ-035 The bench SHALL cover subtract: OPCODE=0011, A=0x05, B=0x07 -> alu_out=0xFE, Cout=0.
REQ-036 The bench SHALL cover multi-cycle shift: OPCODE=1000, A=0xB4, B=0x05 -> in_ready low for 6 cycles, out_valid rises 6 cycles after accept, alu_out=0x05.
REQ-037 The bench SHALL cover backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL cover reset and illegal opcodes:
- Assert rst_n=0 during the third cycle of an OPCODE=1000, B=0x07 shift -> outputs immediately 0 and no out_valid afterwards.
- OPCODE=1111 -> ERR=1, alu_out=0, Z=1.
